mpram_wr_sched: RTL and testbench

MPRAM_WR_SCHED -- requirements
Module: mpram_wr_sched

---
 rtl/mpram_pkg.sv | 15 +
 rtl/mpram_wr_pick.sv | 86 ++++++++
 rtl/mpram_wr_sched.sv | 158 +++++++++++++++
 tb/tb_mpram_wr_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpram_pkg.sv
// Shared definitions for the multi-port RAM write scheduler.
//   sched_state_e : scheduler FSM states (INIT clears the RAM, RUN serves requesters)
//   idx_width()   : bit width needed to index n items, never less than 1
package mpram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mpram_wr_pick.sv
// Combinational round-robin, address-conflict-aware write selector.
// Scans requesters starting at rr_ptr and hands up to WrNum of them to the
// write ports in scan order, skipping any requester whose address is already
// taken this cycle.
// Ports:
//   rr_ptr     in   first requester to consider this cycle
//   req_valid  in   per-requester request
//   req_addr   in   per-requester address
//   grant      out  per-requester grant
//   port_vld   out  per-port "has a grant"
//   port_sel   out  per-port granted requester index
//   any_grant  out  at least one grant this cycle
//   next_ptr   out  (last granted index + 1) mod ReqNum
//   conflict   out  a valid requester lost only because of an address clash
module mpram_wr_pick
  import mpram_pkg::*;
#(
  parameter int AddrW  = 5,
  parameter int WrNum  = 2,
  parameter int ReqNum = 4,
  parameter int IdxW   = idx_width(ReqNum)
) (
  input  logic [IdxW-1:0]                 rr_ptr,
  input  logic [ReqNum-1:0]               req_valid,
  input  logic [ReqNum-1:0][AddrW-1:0]    req_addr,
  output logic [ReqNum-1:0]               grant,
  output logic [WrNum-1:0]                port_vld,
  output logic [WrNum-1:0][IdxW-1:0]      port_sel,
  output logic                            any_grant,
  output logic [IdxW-1:0]                 next_ptr,
  output logic                            conflict
);

  // cnt tracks how many ports are already filled; taken mirrors their
  // addresses so later requesters in the scan can be checked against them.
  // An address clash only counts as a conflict while a port is still free,
  // otherwise the requester lost for lack of ports.
  always_comb begin
    int                          cnt;
    int                          idx;
    logic [IdxW-1:0]             sel;
    logic                        hit;
    logic [WrNum-1:0][AddrW-1:0] taken;

    grant     = '0;
    port_vld  = '0;
    port_sel  = '0;
    any_grant = 1'b0;
    next_ptr  = rr_ptr;
    conflict  = 1'b0;
    cnt       = 0;
    idx       = 0;
    sel       = '0;
    hit       = 1'b0;
    taken     = '0;

    for (int i = 0; i < ReqNum; i++) begin
      idx = (int'(rr_ptr) + i) % ReqNum;
      sel = IdxW'(idx);
      if (req_valid[sel] && (cnt < WrNum)) begin
        hit = 1'b0;
        for (int q = 0; q < WrNum; q++) begin
          if ((q < cnt) && (taken[q] == req_addr[sel])) begin
            hit = 1'b1;
          end
        end
        if (hit) begin
          conflict = 1'b1;
        end else begin
          grant[sel] = 1'b1;
          for (int p = 0; p < WrNum; p++) begin
            if (p == cnt) begin
              port_vld[p] = 1'b1;
              port_sel[p] = sel;
              taken[p]    = req_addr[sel];
            end
          end
          any_grant = 1'b1;
          next_ptr  = IdxW'((idx + 1) % ReqNum);
          cnt       = cnt + 1;
        end
      end
    end
  end

endmodule

// File: rtl/mpram_wr_sched.sv
// Write scheduler in front of a multi-write-port RAM.
// After reset it clears every RAM entry (INIT), then arbitrates up to WrNum
// requester writes per cycle onto the RAM write ports (RUN).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid/addr/data  per-requester write request
//   req_ready      combinational grant, write accepted when valid & ready
//   we/wa/din      registered RAM write enable/address/data per port
//   init_done      high once the RAM clear has completed
//   conflict_cnt   saturating count of cycles with an address-conflict stall
module mpram_wr_sched
  import mpram_pkg::*;
#(
  parameter int Width  = 32,
  parameter int Depth  = 32,
  parameter int WrNum  = 2,
  parameter int ReqNum = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ReqNum-1:0]                      req_valid,
  input  logic [ReqNum-1:0][$clog2(Depth)-1:0]   req_addr,
  input  logic [ReqNum-1:0][Width-1:0]           req_data,
  output logic [ReqNum-1:0]                      req_ready,
  output logic [WrNum-1:0]                       we,
  output logic [WrNum-1:0][$clog2(Depth)-1:0]    wa,
  output logic [WrNum-1:0][Width-1:0]            din,
  output logic                                   init_done,
  output logic [15:0]                            conflict_cnt
);

  localparam int AddrW = $clog2(Depth);
  localparam int IdxW  = idx_width(ReqNum);

  sched_state_e                   state_q, state_d;
  logic [AddrW-1:0]               init_addr_q, init_addr_d;
  logic [IdxW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [WrNum-1:0]               we_q, we_d;
  logic [WrNum-1:0][AddrW-1:0]    wa_q, wa_d;
  logic [WrNum-1:0][Width-1:0]    din_q, din_d;
  logic                           init_done_q, init_done_d;
  logic [15:0]                    conflict_cnt_q, conflict_cnt_d;

  logic [ReqNum-1:0]              grant;
  logic [WrNum-1:0]               port_vld;
  logic [WrNum-1:0][IdxW-1:0]     port_sel;
  logic                           any_grant;
  logic [IdxW-1:0]                next_ptr;
  logic                           conflict;

  mpram_wr_pick #(
    .AddrW  (AddrW),
    .WrNum  (WrNum),
    .ReqNum (ReqNum),
    .IdxW   (IdxW)
  ) u_pick (
    .rr_ptr    (rr_ptr_q),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .grant     (grant),
    .port_vld  (port_vld),
    .port_sel  (port_sel),
    .any_grant (any_grant),
    .next_ptr  (next_ptr),
    .conflict  (conflict)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // INIT clears WrNum entries per cycle; the group that reaches the end of
  // the RAM is the last one, after which we switch to RUN.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == INIT) begin
      init_addr_d = AddrW'((int'(init_addr_q) + WrNum) % Depth);
      if ((int'(init_addr_q) + WrNum) >= Depth) begin
        state_d = RUN;
      end
    end
  end

  // Ports without a write keep their last address/data so the RAM inputs
  // only toggle when something is actually written.
  always_comb begin
    int sum;
    sum            = 0;
    we_d           = '0;
    wa_d           = wa_q;
    din_d          = din_q;
    rr_ptr_d       = rr_ptr_q;
    init_done_d    = init_done_q | (state_q == RUN);
    conflict_cnt_d = conflict_cnt_q;
    req_ready      = '0;
    case (state_q)
      INIT: begin
        for (int p = 0; p < WrNum; p++) begin
          sum = int'(init_addr_q) + p;
          if (sum < Depth) begin
            we_d[p]  = 1'b1;
            wa_d[p]  = AddrW'(sum);
            din_d[p] = '0;
          end
        end
      end
      RUN: begin
        req_ready = grant;
        for (int p = 0; p < WrNum; p++) begin
          if (port_vld[p]) begin
            we_d[p]  = 1'b1;
            wa_d[p]  = req_addr[port_sel[p]];
            din_d[p] = req_data[port_sel[p]];
          end
        end
        if (any_grant) begin
          rr_ptr_d = next_ptr;
        end
        if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
          conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q           <= '0;
      wa_q           <= '0;
      din_q          <= '0;
      rr_ptr_q       <= '0;
      init_done_q    <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      we_q           <= we_d;
      wa_q           <= wa_d;
      din_q          <= din_d;
      rr_ptr_q       <= rr_ptr_d;
      init_done_q    <= init_done_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign we           = we_q;
  assign wa           = wa_q;
  assign din          = din_q;
  assign init_done    = init_done_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mpram_wr_sched.sv
// Directed self-checking bench for mpram_wr_sched (Width=32, Depth=32,
// WrNum=2, ReqNum=4). Expected port writes are queued when stimulus is
// applied and popped after the following clock edge. A simple RAM model
// captures the DUT port writes and is compared against a reference image
// built from the expected writes.
module tb_mpram_wr_sched;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int WN = 2;
  localparam int RN = 4;
  localparam int AW = 5;

  typedef struct {
    logic [WN-1:0]         we;
    logic [WN-1:0][AW-1:0] wa;
    logic [WN-1:0][W-1:0]  din;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic [RN-1:0]         req_valid;
  logic [RN-1:0][AW-1:0] req_addr;
  logic [RN-1:0][W-1:0]  req_data;
  logic [RN-1:0]         req_ready;
  logic [WN-1:0]         we;
  logic [WN-1:0][AW-1:0] wa;
  logic [WN-1:0][W-1:0]  din;
  logic                  init_done;
  logic [15:0]           conflict_cnt;

  exp_t        sb[$];
  logic [W-1:0] ram     [D];
  logic [W-1:0] ref_mem [D];
  int checks = 0;
  int errors = 0;

  mpram_wr_sched #(
    .Width  (W),
    .Depth  (D),
    .WrNum  (WN),
    .ReqNum (RN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .we           (we),
    .wa           (wa),
    .din          (din),
    .init_done    (init_done),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: the port values presented during a cycle are committed at
  // the end of it; capturing at the falling edge keeps clear of the DUT edge.
  always @(negedge clk) begin
    for (int p = 0; p < WN; p++) begin
      if (we[p]) ram[wa[p]] = din[p];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [1:0] we_e, input logic [4:0] a0, input logic [4:0] a1,
                                  input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    e.we     = we_e;
    e.wa[0]  = a0;
    e.wa[1]  = a1;
    e.din[0] = d0;
    e.din[1] = d1;
    return e;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_addr[i]  = a;
    req_data[i]  = d;
  endtask

  // Inputs are already driven; check the combinational grant and queue the
  // port writes that must show up after the next edge.
  task automatic apply_stimulus(input string tag, input logic [3:0] exp_ready, input exp_t e);
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(exp_ready));
    sb.push_back(e);
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_queue: observed empty scoreboard expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_we"}, 64'(we), 64'(e.we));
      for (int p = 0; p < WN; p++) begin
        if (e.we[p]) begin
          check($sformatf("%s_wa%0d", tag, p), 64'(wa[p]), 64'(e.wa[p]));
          check($sformatf("%s_din%0d", tag, p), 64'(din[p]), 64'(e.din[p]));
          ref_mem[e.wa[p]] = e.din[p];
        end
      end
    end
  endtask

  task automatic run_init(input string tag);
    for (int i = 0; i < RN; i++) set_req(i, 1'b1, 5'(i + 20), 32'h5A5A_0000 + 32'(i));
    for (int i = 0; i < D / WN; i++) begin
      apply_stimulus($sformatf("%s%0d", tag, i), 4'b0000,
                     mk_exp(2'b11, 5'(2 * i), 5'(2 * i + 1), 32'd0, 32'd0));
      check_output($sformatf("%s%0d", tag, i));
    end
    check({tag, "_done_early"}, 64'(init_done), 64'd0);
    req_valid = '0;
    apply_stimulus({tag, "_first_run"}, 4'b0000, mk_exp(2'b00, 5'd0, 5'd0, 32'd0, 32'd0));
    check_output({tag, "_first_run"});
    check({tag, "_done"}, 64'(init_done), 64'd1);
    check({tag, "_wa_hold"}, 64'(wa), 64'({5'd31, 5'd30}));
  endtask

  task automatic compare_ram(input string tag);
    for (int a = 0; a < D; a++) begin
      check($sformatf("%s_mem%0d", tag, a), 64'(ram[a]), 64'(ref_mem[a]));
    end
  endtask

  initial begin
    logic dup;
    for (int a = 0; a < D; a++) begin
      ram[a]     = 32'hA5A5_0000 + 32'(a);
      ref_mem[a] = 32'hA5A5_0000 + 32'(a);
    end
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 64'(we), 64'd0);
    check("rst_wa", 64'(wa), 64'd0);
    check("rst_din", 64'(din), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_conflict", 64'(conflict_cnt), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;

    // RAM clear: 16 cycles of address pairs with zero data
    run_init("init");
    for (int a = 0; a < D; a++) check($sformatf("clr_mem%0d", a), 64'(ram[a]), 64'd0);

    // All four valid from rr_ptr=0: req0/1 then req2/3 (rr_ptr moved to 2)
    set_req(0, 1'b1, 5'd1, 32'h1111_0000);
    set_req(1, 1'b1, 5'd2, 32'h2222_0001);
    set_req(2, 1'b1, 5'd3, 32'h3333_0002);
    set_req(3, 1'b1, 5'd4, 32'h4444_0003);
    apply_stimulus("rr_c1", 4'b0011, mk_exp(2'b11, 5'd1, 5'd2, 32'h1111_0000, 32'h2222_0001));
    check_output("rr_c1");
    set_req(0, 1'b1, 5'd6, 32'h6666_0004);
    set_req(1, 1'b1, 5'd7, 32'h7777_0005);
    apply_stimulus("rr_c2", 4'b1100, mk_exp(2'b11, 5'd3, 5'd4, 32'h3333_0002, 32'h4444_0003));
    check_output("rr_c2");
    req_valid = 4'b0011;
    apply_stimulus("rr_c3", 4'b0011, mk_exp(2'b11, 5'd6, 5'd7, 32'h6666_0004, 32'h7777_0005));
    check_output("rr_c3");

    // rr_ptr=2 with req1 and req3: scan order puts req3 on port 0
    req_valid = '0;
    set_req(1, 1'b1, 5'd8, 32'h8888_0006);
    set_req(3, 1'b1, 5'd10, 32'hAAAA_0007);
    apply_stimulus("wrap", 4'b1010, mk_exp(2'b11, 5'd10, 5'd8, 32'hAAAA_0007, 32'h8888_0006));
    check_output("wrap");
    check("conflict_before", 64'(conflict_cnt), 64'd0);

    // Same-address pair: req0 first, req1 held one cycle
    req_valid = '0;
    set_req(0, 1'b1, 5'd5, 32'hFACE_B00C);
    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    apply_stimulus("same_c1", 4'b0001, mk_exp(2'b01, 5'd5, 5'd0, 32'hFACE_B00C, 32'd0));
    check_output("same_c1");
    req_valid[0] = 1'b0;
    apply_stimulus("same_c2", 4'b0010, mk_exp(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0));
    check_output("same_c2");
    req_valid = '0;
    apply_stimulus("same_idle", 4'b0000, mk_exp(2'b00, 5'd0, 5'd0, 32'd0, 32'd0));
    check_output("same_idle");
    check("same_conflict", 64'(conflict_cnt), 64'd1);
    check("same_mem5", 64'(ram[5]), 64'hDEAD_BEEF);

    // Lone requester 3, new address each cycle: always port 0
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      set_req(3, 1'b1, 5'(11 + k), 32'hC0DE_0000 + 32'(k));
      apply_stimulus($sformatf("solo%0d", k), 4'b1000,
                     mk_exp(2'b01, 5'(11 + k), 5'd0, 32'hC0DE_0000 + 32'(k), 32'd0));
      check_output($sformatf("solo%0d", k));
    end
    req_valid = '0;
    apply_stimulus("solo_idle", 4'b0000, mk_exp(2'b00, 5'd0, 5'd0, 32'd0, 32'd0));
    check_output("solo_idle");
    check("solo_conflict", 64'(conflict_cnt), 64'd1);
    compare_ram("run");

    // Reset while init_addr=10, then a full clear from address 0
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < RN; i++) set_req(i, 1'b1, 5'(i), 32'd0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus($sformatf("pre%0d", i), 4'b0000,
                     mk_exp(2'b11, 5'(2 * i), 5'(2 * i + 1), 32'd0, 32'd0));
      check_output($sformatf("pre%0d", i));
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", 64'(we), 64'd0);
    check("mid_rst_wa", 64'(wa), 64'd0);
    check("mid_rst_din", 64'(din), 64'd0);
    check("mid_rst_done", 64'(init_done), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_init("reinit");
    check("reinit_conflict", 64'(conflict_cnt), 64'd0);

    // Permanent same-address pair: every cycle stalls, counter saturates
    req_valid = '0;
    set_req(0, 1'b1, 5'd9, 32'h0000_1234);
    set_req(1, 1'b1, 5'd9, 32'h0000_5678);
    dup = 1'b0;
    for (int k = 1; k <= 70000; k++) begin
      @(posedge clk);
      #1;
      if ((we == 2'b11) && (wa[0] == wa[1])) dup = 1'b1;
      if (k == 100)   check("sat_100", 64'(conflict_cnt), 64'd100);
      if (k == 65534) check("sat_65534", 64'(conflict_cnt), 64'hFFFE);
      if (k == 65535) check("sat_65535", 64'(conflict_cnt), 64'hFFFF);
      if (k == 70000) check("sat_70000", 64'(conflict_cnt), 64'hFFFF);
    end
    check("sat_no_dup", 64'(dup), 64'd0);
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
